axi4_mem_fill_master: RTL and testbench
=======================================

# axi4_mem_fill_master

AXI4 write initiator that fills a region of an AXI4 slave memory with a 64-bit incrementing pattern using fixed-length INCR bursts. It is the driving end of the simulation AXI4 memory: benches and bring-up logic use it to preload or scrub data memory (e.g. at 0x8000_0000) before or alongside the MiV core, without a processor in the loop. It is write-only, keeps one burst in flight, and reports completion and slave error responses.

## Interface
- ID_VALUE, 4'h0: constant driven on AXI_AW_BITS_ID; expected back on AXI_B_BITS_ID.
- BURST_BEATS, 8: beats per burst; power of two, 1..256; BURST_BEATS*8 <= 4096.
- CLK  in  1  sole clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  start request; sampled only in IDLE.
- BASE_ADDR  in  32  region byte address; low log2(BURST_BEATS*8) bits forced to 0 at capture.
- NUM_BURSTS  in  16  bursts to write; 0 is legal.
- SEED  in  64  data value of the first beat.
- BUSY  out  1  high from accepted START until final B handshake.
- DONE  out  1  one-cycle completion pulse.
- ERR  out  1  sticky error flag; cleared by next accepted START.
- AXI_AW_VALID  out  1  write-address valid.
- AXI_AW_READY  in  1  write-address ready.
- AXI_AW_BITS_ID  out  4  = ID_VALUE.
- AXI_AW_BITS_ADDR  out  32  burst start address.
- AXI_AW_BITS_LEN  out  8  = BURST_BEATS-1.
- AXI_AW_BITS_SIZE  out  3  = 3'b011 (8 bytes).
- AXI_AW_BITS_BURST  out  2  = 2'b01 (INCR).
- AXI_W_VALID  out  1  write-data valid.
- AXI_W_READY  in  1  write-data ready.
- AXI_W_BITS_DATA  out  64  beat data.
- AXI_W_BITS_STRB  out  8  = 8'hFF.
- AXI_W_BITS_LAST  out  1  high on final beat of each burst.
- AXI_B_VALID  in  1  write-response valid.
- AXI_B_READY  out  1  write-response ready.
- AXI_B_BITS_ID  in  4  response ID.
- AXI_B_BITS_RESP  in  2  response code.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP, FIN.
- IDLE: START=1 captures BASE_ADDR (masked), NUM_BURSTS, SEED; clears ERR, burst and beat counters. NUM_BURSTS=0 -> FIN; otherwise -> ADDR. START outside IDLE is ignored.
- ADDR: AW_VALID=1, AW_ADDR = base + burst_idx*BURST_BEATS*8, 32-bit modulo 2^32. AW_VALID&AW_READY -> DATA.
- DATA: W_VALID=1, W_DATA = SEED + global beat index (64-bit, wraps). Beat counter advances on W_VALID&W_READY only. W_LAST=1 when beat_in_burst = BURST_BEATS-1; handshake with LAST -> RESP.
- RESP: B_READY=1. On B_VALID: ERR set if RESP!=2'b00 or B_BITS_ID!=ID_VALUE; burst_idx++; if burst_idx+1 = NUM_BURSTS -> FIN, else -> ADDR. Error never aborts the fill.
- FIN: DONE=1 for exactly one cycle, BUSY=0, -> IDLE.
- AXI rules: VALID once raised is held until handshake; ADDR/DATA/LAST stable while VALID and not READY; no VALID depends on READY. AW and W never overlap (W follows AW handshake).
- Constant fields (ID, LEN, SIZE, BURST, STRB) driven at all times including reset.

## Timing
- Reset values: all VALID, B_READY, BUSY, DONE, ERR, W_LAST = 0; AW_ADDR, W_DATA = 0. RESET assertion forces these immediately (async), abandons any in-flight burst; after release FSM is IDLE.
- START accepted at edge T: BUSY and AW_VALID high from T+1.
- First W_VALID in cycle after AW handshake; with W_READY held 1, one beat per cycle.
- B_READY high in cycle after LAST handshake; next AW_VALID in cycle after B handshake.
- Zero-wait slave, B returned immediately: BURST_BEATS+2 cycles per burst.
- DONE in cycle after final B handshake; BUSY low same cycle. NUM_BURSTS=0: DONE at T+1, BUSY stays low.
- ERR updates in cycle after offending B handshake; holds through DONE and IDLE.

## Test plan
- Reset: RESET=1 mid-sim -> all VALID/B_READY/BUSY/DONE/ERR 0 same cycle; LEN=7, SIZE=3, BURST=1, STRB=FF.
- Basic fill: BASE=0x8000_0000, NUM_BURSTS=2, SEED=0x100, always-ready OKAY slave -> AW addrs 0x8000_0000, 0x8000_0040; data 0x100..0x10F; LAST on beats 7, 15; one DONE pulse; ERR=0; memory readback matches.
- Backpressure: AW_READY delayed 5 cycles, W_READY toggling, B_VALID delayed 3 cycles -> VALIDs held, ADDR/DATA stable, 16 beats exactly, no skipped or duplicate data.
- Errors: first B RESP=2'b10, second OKAY -> ERR=1 after first response, second burst still issued, ERR=1 after DONE; next START clears it. Wrong B_BITS_ID also sets ERR.
- Edges: NUM_BURSTS=0 -> DONE at T+1, no AW_VALID; START pulsed while BUSY ignored; BASE=0xFFFF_FFC0, 2 bursts -> second AW addr 0x0000_0000; SEED=0xFFFF_FFFF_FFFF_FFFF -> second beat 0x0.
- Reset mid-DATA on beat 3 -> outputs cleared immediately; after release new START with SEED=0 completes normally from beat 0.

Source files
------------

// File: rtl/axi4_mem_fill_master.sv
// -----------------------------------------------------------------------------
// axi4_mem_fill_master
//
// AXI4 write initiator that fills a region of slave memory with a 64-bit
// incrementing pattern. The region is written as NUM_BURSTS fixed-length INCR
// bursts of BURST_BEATS beats, 8 bytes per beat, one burst in flight at a
// time. Beat n of the fill (counted across all bursts) carries SEED + n.
// Slave error responses or an unexpected response ID raise a sticky ERR flag
// but never abort the fill.
//
// Ports
//   CLK, RESET           clock (rising edge) and asynchronous active-high reset
//   START                start request, sampled only while idle
//   BASE_ADDR            region byte address (aligned down to a burst boundary)
//   NUM_BURSTS           number of bursts to write (0 completes immediately)
//   SEED                 data value of the first beat
//   BUSY, DONE, ERR      status: running, one-cycle completion pulse, sticky error
//   AXI_AW_*             write-address channel (initiator side)
//   AXI_W_*              write-data channel (initiator side)
//   AXI_B_*              write-response channel (initiator side)
// -----------------------------------------------------------------------------
module axi4_mem_fill_master #(
    parameter logic [3:0] ID_VALUE    = 4'h0,
    parameter int         BURST_BEATS = 8
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [31:0] BASE_ADDR,
    input  logic [15:0] NUM_BURSTS,
    input  logic [63:0] SEED,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic        AXI_AW_VALID,
    input  logic        AXI_AW_READY,
    output logic [3:0]  AXI_AW_BITS_ID,
    output logic [31:0] AXI_AW_BITS_ADDR,
    output logic [7:0]  AXI_AW_BITS_LEN,
    output logic [2:0]  AXI_AW_BITS_SIZE,
    output logic [1:0]  AXI_AW_BITS_BURST,
    output logic        AXI_W_VALID,
    input  logic        AXI_W_READY,
    output logic [63:0] AXI_W_BITS_DATA,
    output logic [7:0]  AXI_W_BITS_STRB,
    output logic        AXI_W_BITS_LAST,
    input  logic        AXI_B_VALID,
    output logic        AXI_B_READY,
    input  logic [3:0]  AXI_B_BITS_ID,
    input  logic [1:0]  AXI_B_BITS_RESP
);

    // Burst geometry. The base address is aligned to a whole burst so that no
    // burst can cross a 4 KiB boundary.
    localparam int          BURST_BYTES = BURST_BEATS * 8;
    localparam logic [31:0] BURST_STEP  = 32'(BURST_BYTES);
    localparam logic [31:0] ADDR_MASK   = ~(BURST_STEP - 32'd1);
    localparam logic [7:0]  LAST_BEAT   = 8'(BURST_BEATS - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DATA = 3'd2,
        ST_RESP = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;          // start address of the current burst
    logic [63:0] data_q, data_d;          // data of the beat currently offered
    logic [15:0] num_q, num_d;            // captured burst count
    logic [15:0] burst_idx_q, burst_idx_d;
    logic [7:0]  beat_q, beat_d;          // beat index within the burst
    logic        err_q, err_d;

    logic        aw_valid_q;
    logic        w_valid_q;
    logic        w_last_q;
    logic        b_ready_q;
    logic        busy_q;
    logic        done_q;

    logic        aw_fire_s;
    logic        w_fire_s;
    logic        b_fire_s;
    logic        b_bad_s;
    logic        last_burst_s;

    assign aw_fire_s = aw_valid_q & AXI_AW_READY;
    assign w_fire_s  = w_valid_q & AXI_W_READY;
    assign b_fire_s  = b_ready_q & AXI_B_VALID;
    assign b_bad_s   = (AXI_B_BITS_RESP != 2'b00) || (AXI_B_BITS_ID != ID_VALUE);
    // Widened so that NUM_BURSTS = 16'hFFFF terminates correctly.
    assign last_burst_s = (({1'b0, burst_idx_q} + 17'd1) == {1'b0, num_q});

    // Next-state and datapath update for the fill sequencer.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        num_d       = num_q;
        burst_idx_d = burst_idx_q;
        beat_d      = beat_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    addr_d      = BASE_ADDR & ADDR_MASK;
                    data_d      = SEED;
                    num_d       = NUM_BURSTS;
                    burst_idx_d = 16'd0;
                    beat_d      = 8'd0;
                    err_d       = 1'b0;
                    if (NUM_BURSTS == 16'd0) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ADDR: begin
                if (aw_fire_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_ADDR;
                end
            end

            ST_DATA: begin
                if (w_fire_s) begin
                    // Data runs on across bursts: it is the global beat index.
                    data_d = data_q + 64'd1;
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = 8'd0;
                        state_d = ST_RESP;
                    end else begin
                        beat_d  = beat_q + 8'd1;
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end

            ST_RESP: begin
                if (b_fire_s) begin
                    if (b_bad_s) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    burst_idx_d = burst_idx_q + 16'd1;
                    if (last_burst_s) begin
                        state_d = ST_FIN;
                    end else begin
                        // Address wraps modulo 2^32 by plain 32-bit addition.
                        addr_d  = addr_q + BURST_STEP;
                        state_d = ST_ADDR;
                    end
                end else begin
                    state_d = ST_RESP;
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            addr_q      <= 32'd0;
            data_q      <= 64'd0;
            num_q       <= 16'd0;
            burst_idx_q <= 16'd0;
            beat_q      <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            num_q       <= num_d;
            burst_idx_q <= burst_idx_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
        end
    end

    // Handshake and status outputs, registered from the next state so that no
    // VALID ever depends combinationally on a READY.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            w_last_q   <= 1'b0;
            b_ready_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            aw_valid_q <= (state_d == ST_ADDR);
            w_valid_q  <= (state_d == ST_DATA);
            w_last_q   <= (state_d == ST_DATA) && (beat_d == LAST_BEAT);
            b_ready_q  <= (state_d == ST_RESP);
            busy_q     <= (state_d == ST_ADDR) || (state_d == ST_DATA) ||
                          (state_d == ST_RESP);
            done_q     <= (state_d == ST_FIN);
        end
    end

    assign BUSY              = busy_q;
    assign DONE              = done_q;
    assign ERR               = err_q;

    assign AXI_AW_VALID      = aw_valid_q;
    assign AXI_AW_BITS_ID    = ID_VALUE;
    assign AXI_AW_BITS_ADDR  = addr_q;
    assign AXI_AW_BITS_LEN   = LAST_BEAT;
    assign AXI_AW_BITS_SIZE  = 3'b011;
    assign AXI_AW_BITS_BURST = 2'b01;

    assign AXI_W_VALID       = w_valid_q;
    assign AXI_W_BITS_DATA   = data_q;
    assign AXI_W_BITS_STRB   = 8'hFF;
    assign AXI_W_BITS_LAST   = w_last_q;

    assign AXI_B_READY       = b_ready_q;

endmodule

// File: tb/tb_axi4_mem_fill_master.sv
// -----------------------------------------------------------------------------
// Self-checking bench for axi4_mem_fill_master. A behavioural AXI4 slave with
// configurable AW/B latency and W backpressure stores every accepted beat in
// an associative memory. Expected AW addresses, beat data and LAST flags are
// computed from the fill rules (aligned base + i*64, SEED + global beat index)
// and compared as handshakes occur; the stored memory is compared at the end
// of every fill.
// -----------------------------------------------------------------------------
module tb_axi4_mem_fill_master;

    localparam int BEATS = 8;
    localparam int BYTES = BEATS * 8;

    logic        CLK;
    logic        RESET;
    logic        START;
    logic [31:0] BASE_ADDR;
    logic [15:0] NUM_BURSTS;
    logic [63:0] SEED;
    logic        BUSY, DONE, ERR;
    logic        AXI_AW_VALID, AXI_AW_READY;
    logic [3:0]  AXI_AW_BITS_ID;
    logic [31:0] AXI_AW_BITS_ADDR;
    logic [7:0]  AXI_AW_BITS_LEN;
    logic [2:0]  AXI_AW_BITS_SIZE;
    logic [1:0]  AXI_AW_BITS_BURST;
    logic        AXI_W_VALID, AXI_W_READY;
    logic [63:0] AXI_W_BITS_DATA;
    logic [7:0]  AXI_W_BITS_STRB;
    logic        AXI_W_BITS_LAST;
    logic        AXI_B_VALID, AXI_B_READY;
    logic [3:0]  AXI_B_BITS_ID;
    logic [1:0]  AXI_B_BITS_RESP;

    axi4_mem_fill_master #(.ID_VALUE(4'h0), .BURST_BEATS(BEATS)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .BASE_ADDR(BASE_ADDR),
        .NUM_BURSTS(NUM_BURSTS), .SEED(SEED), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .AXI_AW_VALID(AXI_AW_VALID), .AXI_AW_READY(AXI_AW_READY),
        .AXI_AW_BITS_ID(AXI_AW_BITS_ID), .AXI_AW_BITS_ADDR(AXI_AW_BITS_ADDR),
        .AXI_AW_BITS_LEN(AXI_AW_BITS_LEN), .AXI_AW_BITS_SIZE(AXI_AW_BITS_SIZE),
        .AXI_AW_BITS_BURST(AXI_AW_BITS_BURST),
        .AXI_W_VALID(AXI_W_VALID), .AXI_W_READY(AXI_W_READY),
        .AXI_W_BITS_DATA(AXI_W_BITS_DATA), .AXI_W_BITS_STRB(AXI_W_BITS_STRB),
        .AXI_W_BITS_LAST(AXI_W_BITS_LAST),
        .AXI_B_VALID(AXI_B_VALID), .AXI_B_READY(AXI_B_READY),
        .AXI_B_BITS_ID(AXI_B_BITS_ID), .AXI_B_BITS_RESP(AXI_B_BITS_RESP)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [31:0] base;
        logic [15:0] n;
        logic [63:0] seed;
        int          aw_lat;
        int          b_lat;
        int          w_mode;      // 0 always ready, 1 toggling, 2 random
        logic [1:0]  resp0;       // response for the first burst
        logic [3:0]  id0;         // response ID for the first burst
        logic        exp_err;
        int          exp_cycles;  // cycles from START to DONE, -1 = not checked
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    int n_cmp, n_bad;

    // Expected traffic and slave state
    logic [31:0] exp_addr_q [$];
    logic [63:0] exp_data_q [$];
    logic        exp_last_q [$];
    logic [1:0]  resp_q [$];
    logic [3:0]  bid_q [$];
    logic [63:0] mem_act [logic [31:0]];

    int          aw_lat, b_lat, w_mode;
    int          aw_wait, b_wait, b_todo;
    logic        aw_pend, w_pend, b_fired;
    logic [31:0] aw_addr_prev, cur_addr;
    logic [63:0] w_data_prev;
    logic        w_last_prev;
    int          beat_k;
    int          job_cycles, done_at, job_beats;
    logic        job_done, exp_err;
    logic [31:0] job_base;
    logic [15:0] job_n;
    logic [63:0] job_seed;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic slave_clear();
        AXI_AW_READY    = 1'b0;
        AXI_W_READY     = 1'b0;
        AXI_B_VALID     = 1'b0;
        AXI_B_BITS_RESP = 2'b00;
        AXI_B_BITS_ID   = 4'h0;
        aw_wait = 0; b_wait = 0; b_todo = 0; beat_k = 0;
        aw_pend = 1'b0; w_pend = 1'b0; b_fired = 1'b0;
        cur_addr = 32'd0; aw_addr_prev = 32'd0; w_data_prev = 64'd0; w_last_prev = 1'b0;
        resp_q.delete(); bid_q.delete();
        exp_err = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_aw_valid", 64'(AXI_AW_VALID), 64'd0);
        chk("rst_w_valid", 64'(AXI_W_VALID), 64'd0);
        chk("rst_b_ready", 64'(AXI_B_READY), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_done", 64'(DONE), 64'd0);
        chk("rst_err", 64'(ERR), 64'd0);
        chk("rst_w_last", 64'(AXI_W_BITS_LAST), 64'd0);
        chk("rst_aw_addr", 64'(AXI_AW_BITS_ADDR), 64'd0);
        chk("rst_w_data", AXI_W_BITS_DATA, 64'd0);
        chk("rst_len", 64'(AXI_AW_BITS_LEN), 64'd7);
        chk("rst_size", 64'(AXI_AW_BITS_SIZE), 64'd3);
        chk("rst_burst", 64'(AXI_AW_BITS_BURST), 64'd1);
        chk("rst_strb", 64'(AXI_W_BITS_STRB), 64'hFF);
        chk("rst_id", 64'(AXI_AW_BITS_ID), 64'd0);
    endtask

    // One clock of the slave: observe at the falling edge, decide readies for
    // the coming rising edge, and record the handshakes that edge will make.
    task automatic tick();
        logic [63:0] ed;
        logic        el;
        logic [1:0]  rr;
        logic [3:0]  ii;
        @(negedge CLK);
        job_cycles++;
        chk("err_flag", 64'(ERR), 64'(exp_err));
        chk("aw_w_overlap", 64'(AXI_AW_VALID & AXI_W_VALID), 64'd0);
        if (aw_pend) begin
            chk("aw_valid_held", 64'(AXI_AW_VALID), 64'd1);
            chk("aw_addr_stable", 64'(AXI_AW_BITS_ADDR), 64'(aw_addr_prev));
        end
        if (w_pend) begin
            chk("w_valid_held", 64'(AXI_W_VALID), 64'd1);
            chk("w_data_stable", AXI_W_BITS_DATA, w_data_prev);
            chk("w_last_stable", 64'(AXI_W_BITS_LAST), 64'(w_last_prev));
        end
        if (DONE && !job_done) begin
            job_done = 1'b1;
            done_at  = job_cycles;
        end

        // Write response: only after the LAST beat has been accepted.
        if (b_fired) begin
            AXI_B_VALID = 1'b0;
            b_fired     = 1'b0;
        end
        if (!AXI_B_VALID && b_todo > 0) begin
            if (b_wait >= b_lat) begin
                rr = 2'b00;
                ii = 4'h0;
                if (resp_q.size() > 0) rr = resp_q.pop_front();
                if (bid_q.size() > 0) ii = bid_q.pop_front();
                AXI_B_VALID     = 1'b1;
                AXI_B_BITS_RESP = rr;
                AXI_B_BITS_ID   = ii;
                b_todo--;
                b_wait = 0;
            end else begin
                b_wait++;
            end
        end
        if (AXI_B_VALID && AXI_B_READY) begin
            b_fired = 1'b1;
            if (AXI_B_BITS_RESP != 2'b00 || AXI_B_BITS_ID != 4'h0) exp_err = 1'b1;
        end

        // Write address
        AXI_AW_READY = 1'b0;
        if (AXI_AW_VALID) begin
            if (aw_wait >= aw_lat) begin
                AXI_AW_READY = 1'b1;
                aw_wait = 0;
                chk("aw_len", 64'(AXI_AW_BITS_LEN), 64'(BEATS - 1));
                chk("aw_size", 64'(AXI_AW_BITS_SIZE), 64'd3);
                chk("aw_burst", 64'(AXI_AW_BITS_BURST), 64'd1);
                chk("aw_id", 64'(AXI_AW_BITS_ID), 64'd0);
                if (exp_addr_q.size() == 0) begin
                    chk("aw_unexpected", 64'(AXI_AW_VALID), 64'd0);
                end else begin
                    chk("aw_addr", 64'(AXI_AW_BITS_ADDR), 64'(exp_addr_q.pop_front()));
                end
                cur_addr = AXI_AW_BITS_ADDR;
                beat_k   = 0;
            end else begin
                aw_wait++;
            end
        end
        aw_pend      = AXI_AW_VALID && !AXI_AW_READY;
        aw_addr_prev = AXI_AW_BITS_ADDR;

        // Write data
        case (w_mode)
            0:       AXI_W_READY = 1'b1;
            1:       AXI_W_READY = ~AXI_W_READY;
            default: AXI_W_READY = 1'($urandom_range(0, 1));
        endcase
        if (AXI_W_VALID && AXI_W_READY) begin
            chk("w_strb", 64'(AXI_W_BITS_STRB), 64'hFF);
            if (exp_data_q.size() == 0) begin
                chk("w_unexpected", 64'(AXI_W_VALID), 64'd0);
            end else begin
                ed = exp_data_q.pop_front();
                el = exp_last_q.pop_front();
                chk("w_data", AXI_W_BITS_DATA, ed);
                chk("w_last", 64'(AXI_W_BITS_LAST), 64'(el));
            end
            mem_act[cur_addr + 32'(beat_k * 8)] = AXI_W_BITS_DATA;
            beat_k++;
            job_beats++;
            if (AXI_W_BITS_LAST) b_todo++;
        end
        w_pend      = AXI_W_VALID && !AXI_W_READY;
        w_data_prev = AXI_W_BITS_DATA;
        w_last_prev = AXI_W_BITS_LAST;
    endtask

    // Build the expected trace and issue START for one cycle.
    task automatic start_job(input logic [31:0] base, input logic [15:0] n,
                             input logic [63:0] seed, input int awl, input int bl,
                             input int wm);
        logic [31:0] ab;
        job_base = base; job_n = n; job_seed = seed;
        aw_lat = awl; b_lat = bl; w_mode = wm;
        exp_addr_q.delete(); exp_data_q.delete(); exp_last_q.delete(); mem_act.delete();
        ab = base & ~(32'(BYTES) - 32'd1);
        for (int i = 0; i < int'(n); i++) begin
            exp_addr_q.push_back(ab + 32'(i * BYTES));
            for (int k = 0; k < BEATS; k++) begin
                exp_data_q.push_back(seed + 64'(i * BEATS + k));
                exp_last_q.push_back(k == BEATS - 1);
            end
        end
        job_cycles = 0; job_done = 1'b0; done_at = 0; job_beats = 0;
        exp_err = 1'b0;
        START = 1'b1; BASE_ADDR = base; NUM_BURSTS = n; SEED = seed;
        tick();
        START = 1'b0;
        chk("busy_after_start", 64'(BUSY), 64'(n != 16'd0));
        chk("aw_valid_after_start", 64'(AXI_AW_VALID), 64'(n != 16'd0));
        chk("done_after_start", 64'(DONE), 64'(n == 16'd0));
    endtask

    // Run until DONE (bounded) and check completion, memory and ERR.
    task automatic finish_job(input logic exp_err_final, input int exp_cycles);
        logic [31:0] a;
        while (!job_done && job_cycles < 3000) tick();
        chk("done_seen", 64'(job_done), 64'd1);
        if (job_done) begin
            if (exp_cycles >= 0) chk("done_latency", 64'(done_at), 64'(exp_cycles));
            chk("busy_at_done", 64'(BUSY), 64'd0);
        end
        chk("aw_all_issued", 64'(exp_addr_q.size()), 64'd0);
        chk("w_all_issued", 64'(exp_data_q.size()), 64'd0);
        chk("beat_count", 64'(job_beats), 64'(int'(job_n) * BEATS));
        for (int i = 0; i < int'(job_n); i++) begin
            for (int k = 0; k < BEATS; k++) begin
                a = (job_base & ~(32'(BYTES) - 32'd1)) + 32'(i * BYTES + k * 8);
                chk("mem_present", 64'(mem_act.exists(a)), 64'd1);
                if (mem_act.exists(a)) chk("mem_data", mem_act[a], job_seed + 64'(i * BEATS + k));
            end
        end
        chk("err_final", 64'(ERR), 64'(exp_err_final));
        tick();
        chk("done_pulse_width", 64'(DONE), 64'd0);
        chk("busy_idle", 64'(BUSY), 64'd0);
    endtask

    initial begin
        logic [15:0] rn;
        logic        bad;
        logic [1:0]  rr;
        logic [3:0]  ii;
        n_cmp = 0; n_bad = 0;
        RESET = 1'b1; START = 1'b0; BASE_ADDR = 32'd0; NUM_BURSTS = 16'd0; SEED = 64'd0;
        aw_lat = 0; b_lat = 0; w_mode = 0;
        job_cycles = 0; job_done = 1'b0; done_at = 0; job_beats = 0;
        job_base = 32'd0; job_n = 16'd0; job_seed = 64'd0;
        slave_clear();

        //            base          n      seed                   awl bl wm resp0  id0   err   cycles
        vecs[0] = '{32'h8000_0000, 16'd2, 64'h100,                0, 0, 0, 2'b00, 4'h0, 1'b0, 21};
        vecs[1] = '{32'h8000_0000, 16'd2, 64'h200,                5, 3, 1, 2'b00, 4'h0, 1'b0, -1};
        vecs[2] = '{32'h0000_1000, 16'd2, 64'h300,                0, 0, 0, 2'b10, 4'h0, 1'b1, 21};
        vecs[3] = '{32'h0000_2000, 16'd1, 64'h400,                0, 0, 0, 2'b00, 4'h0, 1'b0, 11};
        vecs[4] = '{32'h0000_3000, 16'd2, 64'h500,                1, 1, 2, 2'b00, 4'h3, 1'b1, -1};
        vecs[5] = '{32'h8000_0000, 16'd0, 64'h600,                0, 0, 0, 2'b00, 4'h0, 1'b0, 1};
        vecs[6] = '{32'hFFFF_FFC0, 16'd2, 64'h700,                0, 0, 0, 2'b00, 4'h0, 1'b0, 21};
        vecs[7] = '{32'h4000_0000, 16'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 2'b00, 4'h0, 1'b0, 11};
        vecs[8] = '{32'h8000_0027, 16'd1, 64'h800,                0, 2, 1, 2'b00, 4'h0, 1'b0, -1};

        #1;
        check_reset_vals();
        repeat (3) @(negedge CLK);
        RESET = 1'b0;

        // Directed table
        for (int v = 0; v < NV; v++) begin
            resp_q.delete(); bid_q.delete();
            resp_q.push_back(vecs[v].resp0);
            bid_q.push_back(vecs[v].id0);
            for (int b = 1; b < int'(vecs[v].n); b++) begin
                resp_q.push_back(2'b00);
                bid_q.push_back(4'h0);
            end
            start_job(vecs[v].base, vecs[v].n, vecs[v].seed,
                      vecs[v].aw_lat, vecs[v].b_lat, vecs[v].w_mode);
            finish_job(vecs[v].exp_err, vecs[v].exp_cycles);
        end

        // START while busy is ignored
        resp_q.delete(); bid_q.delete();
        resp_q.push_back(2'b00); bid_q.push_back(4'h0);
        start_job(32'h0000_5000, 16'd1, 64'h900, 0, 0, 0);
        repeat (4) tick();
        START = 1'b1; BASE_ADDR = 32'h1234_0000; NUM_BURSTS = 16'd5; SEED = 64'hABCD;
        tick();
        START = 1'b0;
        finish_job(1'b0, 11);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("no_restart_aw", 64'(AXI_AW_VALID), 64'd0);
            chk("no_restart_busy", 64'(BUSY), 64'd0);
        end

        // Reset on beat 3 of the second burst, with ERR already set by burst 0
        resp_q.delete(); bid_q.delete();
        resp_q.push_back(2'b10); resp_q.push_back(2'b00);
        bid_q.push_back(4'h0); bid_q.push_back(4'h0);
        start_job(32'h8000_0000, 16'd2, 64'h1000, 0, 0, 0);
        while (job_beats < 11 && job_cycles < 200) tick();
        @(posedge CLK);
        #2;
        chk("pre_reset_beat", AXI_W_BITS_DATA, 64'h100B);
        chk("pre_reset_err", 64'(ERR), 64'd1);
        RESET = 1'b1;
        #1;
        check_reset_vals();
        @(negedge CLK);
        @(negedge CLK);
        slave_clear();
        RESET = 1'b0;
        resp_q.push_back(2'b00); bid_q.push_back(4'h0);
        start_job(32'h8000_0000, 16'd1, 64'd0, 0, 0, 0);
        finish_job(1'b0, 11);

        // Randomized fills against the reference trace
        for (int r = 0; r < 25; r++) begin
            resp_q.delete(); bid_q.delete();
            rn  = 16'($urandom_range(0, 4));
            bad = 1'b0;
            for (int b = 0; b < int'(rn); b++) begin
                rr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                ii = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
                if (rr != 2'b00 || ii != 4'h0) bad = 1'b1;
                resp_q.push_back(rr);
                bid_q.push_back(ii);
            end
            start_job($urandom, rn, {$urandom, $urandom},
                      $urandom_range(0, 3), $urandom_range(0, 3), 2);
            finish_job(bad, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
